// File: rtl/fifo_sync_if.sv
// rtl/fifo_sync_if.sv - producer/consumer bundle for fifo_sync
// slave is the FIFO side, master is the surrounding logic.
interface fifo_sync_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 8
);
  logic                  write_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  write_en, data_in, read_en, err_clr,
    output data_out, full, almost_full, empty, almost_empty, count, overflow, underflow
  );

  modport master (
    output write_en, data_in, read_en, err_clr,
    input  data_out, full, almost_full, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock first-word-fall-through FIFO
// Registered head word, occupancy count, threshold flags and sticky error flags.
module fifo_sync #(
  parameter int DATA_WIDTH          = 512,
  parameter int ADDR_WIDTH          = 8,
  parameter int ALMOST_FULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int ALMOST_EMPTY_THRESH = 4
) (
  input  logic       clk,
  input  logic       rst,
  fifo_sync_if.slave bus
);
  localparam int                  DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = ALMOST_FULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = ALMOST_EMPTY_THRESH[ADDR_WIDTH:0];

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 12) begin : g_bad_addr_width
    $error("fifo_sync: ADDR_WIDTH out of range 1..12");
  end
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_af_thresh
    $error("fifo_sync: ALMOST_FULL_THRESH out of range 1..DEPTH");
  end
  if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > DEPTH - 1) begin : g_bad_ae_thresh
    $error("fifo_sync: ALMOST_EMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_rd_ptr_nxt;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_load;
  logic                  w_bypass;

  assign w_full       = (r_count == DEPTH_C);
  assign w_empty      = (r_count == '0);
  assign w_wr_acc     = bus.write_en & ~w_full;
  assign w_rd_acc     = bus.read_en & ~w_empty;
  assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
  assign w_count_nxt  = r_count + {{ADDR_WIDTH{1'b0}}, w_wr_acc} - {{ADDR_WIDTH{1'b0}}, w_rd_acc};

  // The head register reloads whenever the head moves or the FIFO leaves empty;
  // if the new head is the word being written this cycle, take it from data_in.
  assign w_load   = (w_rd_acc | w_empty) & (w_count_nxt != '0);
  assign w_bypass = w_wr_acc & (w_rd_ptr_nxt == r_wr_ptr);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_load) begin
        r_dout <= w_bypass ? bus.data_in : r_mem[w_rd_ptr_nxt[ADDR_WIDTH-1:0]];
      end
      // A fresh error outranks err_clr in the same cycle.
      if (bus.write_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_overflow <= 1'b0;
      end
      if (bus.read_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.data_out     = r_dout;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_C);
  assign bus.almost_empty = (r_count <= AE_C);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - scoreboard bench for fifo_sync
// DEPTH=4, almost_full at 3, almost_empty at 1.
module tb_fifo_sync;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [7:0] sb [$];

  fifo_sync_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  fifo_sync #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2),
    .ALMOST_FULL_THRESH(3),
    .ALMOST_EMPTY_THRESH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [7:0] din, input logic re, input logic clr);
    bus.write_en = we;
    bus.data_in  = din;
    bus.read_en  = re;
    bus.err_clr  = clr;
  endtask

  task automatic push_word(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
    sb.push_back(d);
    tick();
  endtask

  task automatic pop_word();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic idle_clr();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: a word is consumed at the next posedge when read_en is high and empty is low.
  always @(negedge clk) begin
    if (!rst && bus.read_en && !bus.empty) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_pop: unexpected word 0x%0h, expected none", bus.data_out);
      end else begin
        chk("sb_data", 32'(bus.data_out), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_aempty", 32'(bus.almost_empty), 1);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_dout", 32'(bus.data_out), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_udf", 32'(bus.underflow), 0);
    rst = 1'b0;

    // 1: first write falls through in one cycle
    push_word(8'hA1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_empty", 32'(bus.empty), 0);
    chk("t1_dout", 32'(bus.data_out), 32'hA1);
    chk("t1_count", 32'(bus.count), 1);
    chk("t1_aempty", 32'(bus.almost_empty), 1);
    pop_word();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_empty_after", 32'(bus.empty), 1);

    // 2: fill, overflow, drain
    for (int i = 1; i <= 4; i++) begin
      push_word(8'(i * 8'h11));
      chk("t2_count", 32'(bus.count), 32'(i));
      chk("t2_afull", 32'(bus.almost_full), (i >= 3) ? 1 : 0);
      chk("t2_full", 32'(bus.full), (i == 4) ? 1 : 0);
    end
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_ovf", 32'(bus.overflow), 1);
    chk("t2_count_full", 32'(bus.count), 4);
    for (int i = 1; i <= 4; i++) begin
      pop_word();
      chk("t2_drain_count", 32'(bus.count), 32'(4 - i));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_empty", 32'(bus.empty), 1);
    chk("t2_dout_held", 32'(bus.data_out), 32'h44);
    idle_clr();
    chk("t2_ovf_clr", 32'(bus.overflow), 0);

    // 3: underflow and err_clr priority
    pop_word();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_udf", 32'(bus.underflow), 1);
    chk("t3_count", 32'(bus.count), 0);
    idle_clr();
    chk("t3_udf_clr", 32'(bus.underflow), 0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_udf_wins", 32'(bus.underflow), 1);
    idle_clr();

    // 4: streaming at count=2 across several pointer wraps
    push_word(8'hF0);
    push_word(8'hF1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      sb.push_back(8'(i));
      tick();
      chk("t4_count", 32'(bus.count), 2);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_ovf", 32'(bus.overflow), 0);
    chk("t4_udf", 32'(bus.underflow), 0);
    pop_word();
    pop_word();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_empty", 32'(bus.empty), 1);

    // 5: read+write at full, then at empty
    for (int i = 1; i <= 4; i++) push_word(8'(8'h60 + i));
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_full_count", 32'(bus.count), 3);
    chk("t5_full_ovf", 32'(bus.overflow), 1);
    for (int i = 0; i < 3; i++) pop_word();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_drained", 32'(bus.empty), 1);
    idle_clr();
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    sb.push_back(8'h77);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_empty_count", 32'(bus.count), 1);
    chk("t5_empty_dout", 32'(bus.data_out), 32'h77);
    chk("t5_empty_udf", 32'(bus.underflow), 1);
    pop_word();
    idle_clr();

    // 6: reset mid-operation with write and read asserted
    for (int i = 1; i <= 3; i++) push_word(8'(8'h30 + i));
    rst = 1'b1;
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    sb.delete();
    chk("t6_count", 32'(bus.count), 0);
    chk("t6_empty", 32'(bus.empty), 1);
    chk("t6_dout", 32'(bus.data_out), 0);
    chk("t6_full", 32'(bus.full), 0);
    chk("t6_afull", 32'(bus.almost_full), 0);
    chk("t6_aempty", 32'(bus.almost_empty), 1);
    chk("t6_ovf", 32'(bus.overflow), 0);
    chk("t6_udf", 32'(bus.underflow), 0);
    push_word(8'h5A);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_dout_5a", 32'(bus.data_out), 32'h5A);
    pop_word();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_empty_end", 32'(bus.empty), 1);

    tick();
    chk("sb_leftover", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
